// File: rtl/mux_pkg.sv
// Shared elaboration helpers for the pipelined word mux tree: stage count,
// per-stage level count, per-stage word count and packed-word indexing.
package mux_pkg;

    function automatic int unsigned stages(input int unsigned l, input int unsigned lps);
        return (l + lps - 1) / lps;
    endfunction

    function automatic int unsigned stage_levels(input int unsigned k, input int unsigned l,
                                                 input int unsigned lps);
        int unsigned rem;
        rem = l - k * lps;
        return (rem < lps) ? rem : lps;
    endfunction

    // Words entering stage k; each stage divides the count by 2^levels, rounding up.
    function automatic int unsigned stage_words(input int unsigned k, input int unsigned n,
                                                input int unsigned l, input int unsigned lps);
        int unsigned w;
        w = n;
        for (int unsigned t = 0; t < k; t++) begin
            w = (w + (1 << stage_levels(t, l, lps)) - 1) >> stage_levels(t, l, lps);
        end
        return w;
    endfunction

    function automatic int unsigned word_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// Combinational reduction of N_IN packed words by LEVELS binary 2:1 levels;
// missing leaves of a non-power-of-two input set read as zero.
module mux_tree_stage
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned N_IN   = 32,
    parameter int unsigned LEVELS = 2,
    localparam int unsigned N_OUT = (N_IN + (1 << LEVELS) - 1) >> LEVELS
) (
    input  logic [N_IN*WIDTH-1:0]  in_words,
    input  logic [LEVELS-1:0]      sel,
    output logic [N_OUT*WIDTH-1:0] out_words
);

    localparam int unsigned NPAD = N_OUT << LEVELS;

    // Level j occupies nodes [lvl_off(j), lvl_off(j) + NPAD>>j) of one flat vector.
    function automatic int unsigned lvl_off(input int unsigned j);
        return 2 * NPAD - 2 * (NPAD >> j);
    endfunction

    localparam int unsigned NODES = lvl_off(LEVELS) + N_OUT;

    logic [NODES*WIDTH-1:0] node;

    for (genvar i = 0; i < NPAD; i++) begin : g_leaf
        if (i < N_IN) begin : g_real
            assign node[word_lo(i, WIDTH) +: WIDTH] = in_words[word_lo(i, WIDTH) +: WIDTH];
        end else begin : g_pad
            assign node[word_lo(i, WIDTH) +: WIDTH] = '0;
        end
    end

    for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
        for (genvar m = 0; m < (NPAD >> j); m++) begin : g_node
            assign node[word_lo(lvl_off(j) + m, WIDTH) +: WIDTH] = sel[j-1]
                ? node[word_lo(lvl_off(j-1) + 2*m + 1, WIDTH) +: WIDTH]
                : node[word_lo(lvl_off(j-1) + 2*m, WIDTH) +: WIDTH];
        end
    end

    assign out_words = node[word_lo(lvl_off(LEVELS), WIDTH) +: N_OUT*WIDTH];

endmodule

// File: rtl/mux_tree_pipe.sv
// N_INPUTS:1 word multiplexer tree with a register stage every LEVELS_PER_STAGE
// levels and a valid/ready chain with full backpressure.
module mux_tree_pipe
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH            = 64,
    parameter int unsigned N_INPUTS         = 32,
    parameter int unsigned LEVELS_PER_STAGE = 2,
    localparam int unsigned SEL_W           = $clog2(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_err
);

    localparam int unsigned S = stages(SEL_W, LEVELS_PER_STAGE);

    logic [S-1:0] v_q, v_d;
    logic [S:0]   ld;
    logic [S:0]   v_up;

    // Load enables ripple back from the consumer; ld[S] is the consumer itself.
    always_comb begin
        ld    = '0;
        ld[S] = out_ready;
        for (int unsigned i = 0; i < S; i++) begin
            ld[S-1-i] = !v_q[S-1-i] || ld[S-i];
        end
    end

    assign v_up = {v_q, in_valid};

    always_comb begin
        v_d = v_q;
        for (int unsigned k = 0; k < S; k++) begin
            if (ld[k]) v_d[k] = v_up[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) v_q <= '0;
        else          v_q <= v_d;
    end

    for (genvar k = 0; k < S; k++) begin : g_st
        localparam int unsigned LV = stage_levels(k, SEL_W, LEVELS_PER_STAGE);
        localparam int unsigned NI = stage_words(k, N_INPUTS, SEL_W, LEVELS_PER_STAGE);
        localparam int unsigned NO = stage_words(k + 1, N_INPUTS, SEL_W, LEVELS_PER_STAGE);
        localparam int unsigned RI = SEL_W - k * LEVELS_PER_STAGE;
        localparam int unsigned RO = RI - LV;

        logic [NI*WIDTH-1:0] din;
        logic [RI-1:0]       sin;
        logic                ein;
        logic [NO*WIDTH-1:0] red, data_d, data_q;
        logic                err_d, err_q;

        if (k == 0) begin : g_in
            assign din = in_data;
            assign sin = in_sel;
            assign ein = ({1'b0, in_sel} >= (SEL_W + 1)'(N_INPUTS));
        end else begin : g_link
            assign din = g_st[k-1].data_q;
            assign sin = g_st[k-1].g_sel.sel_q;
            assign ein = g_st[k-1].err_q;
        end

        mux_tree_stage #(
            .WIDTH (WIDTH),
            .N_IN  (NI),
            .LEVELS(LV)
        ) u_tree (
            .in_words (din),
            .sel      (sin[LV-1:0]),
            .out_words(red)
        );

        always_comb begin
            data_d = ld[k] ? red : data_q;
            err_d  = ld[k] ? ein : err_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
                err_q  <= 1'b0;
            end else begin
                data_q <= data_d;
                err_q  <= err_d;
            end
        end

        // Only the select bits still needed downstream travel with the beat.
        if (RO > 0) begin : g_sel
            logic [RO-1:0] sel_d, sel_q;

            always_comb sel_d = ld[k] ? sin[RI-1:LV] : sel_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sel_q <= '0;
                else          sel_q <= sel_d;
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[S-1];
    assign out_data  = g_st[S-1].data_q;
    assign out_err   = g_st[S-1].err_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: three configurations driven through one
// shared stimulus/observation port, checked against a queue-based reference model.
module tb_mux_tree_pipe;

    typedef struct {
        logic [63:0] d;
        logic        e;
        int unsigned acc;
    } beat_t;

    logic clk, reset_n;
    int   cur;
    int   n_tests, n_fail;
    int unsigned cyc, out_cnt;
    bit   lat_chk;
    beat_t sb[$];

    logic          drv_valid, drv_oready;
    logic [5:0]    drv_sel;
    logic [2047:0] drv_data;
    logic          obs_ready, obs_ovalid, obs_oerr;
    logic [63:0]   obs_odata;

    logic        a_in_ready, a_out_valid, a_out_err;
    logic [63:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_err;
    logic [7:0]  b_out_data;
    logic        c_in_ready, c_out_valid, c_out_err;
    logic [15:0] c_out_data;

    mux_tree_pipe #(.WIDTH(64), .N_INPUTS(32), .LEVELS_PER_STAGE(2)) u_a (
        .clk(clk), .reset_n(reset_n),
        .in_valid(drv_valid && cur == 0), .in_ready(a_in_ready),
        .in_data(drv_data[32*64-1:0]), .in_sel(drv_sel[4:0]),
        .out_valid(a_out_valid), .out_ready(cur == 0 ? drv_oready : 1'b1),
        .out_data(a_out_data), .out_err(a_out_err)
    );

    mux_tree_pipe #(.WIDTH(8), .N_INPUTS(20), .LEVELS_PER_STAGE(1)) u_b (
        .clk(clk), .reset_n(reset_n),
        .in_valid(drv_valid && cur == 1), .in_ready(b_in_ready),
        .in_data(drv_data[20*8-1:0]), .in_sel(drv_sel[4:0]),
        .out_valid(b_out_valid), .out_ready(cur == 1 ? drv_oready : 1'b1),
        .out_data(b_out_data), .out_err(b_out_err)
    );

    mux_tree_pipe #(.WIDTH(16), .N_INPUTS(4), .LEVELS_PER_STAGE(4)) u_c (
        .clk(clk), .reset_n(reset_n),
        .in_valid(drv_valid && cur == 2), .in_ready(c_in_ready),
        .in_data(drv_data[4*16-1:0]), .in_sel(drv_sel[1:0]),
        .out_valid(c_out_valid), .out_ready(cur == 2 ? drv_oready : 1'b1),
        .out_data(c_out_data), .out_err(c_out_err)
    );

    always_comb begin
        obs_ready  = a_in_ready;
        obs_ovalid = a_out_valid;
        obs_odata  = a_out_data;
        obs_oerr   = a_out_err;
        if (cur == 1) begin
            obs_ready  = b_in_ready;
            obs_ovalid = b_out_valid;
            obs_odata  = {56'd0, b_out_data};
            obs_oerr   = b_out_err;
        end else if (cur == 2) begin
            obs_ready  = c_in_ready;
            obs_ovalid = c_out_valid;
            obs_odata  = {48'd0, c_out_data};
            obs_oerr   = c_out_err;
        end
    end

    function automatic int unsigned n_of(input int c);
        return (c == 0) ? 32 : (c == 1) ? 20 : 4;
    endfunction

    function automatic int unsigned w_of(input int c);
        return (c == 0) ? 64 : (c == 1) ? 8 : 16;
    endfunction

    function automatic int unsigned s_of(input int c);
        return (c == 0) ? 3 : (c == 1) ? 5 : 1;
    endfunction

    function automatic logic [63:0] pat(input int c, input int unsigned k);
        return (c == 0) ? 64'hA5A5_0000_0000_0000 + 64'(k)
             : (c == 1) ? 64'h40 + 64'(k) : 64'hC000 + 64'(k);
    endfunction

    // Reference: word `s` of the packed input, or zero when s is out of range.
    function automatic logic [63:0] model_word(input int c, input logic [2047:0] d,
                                               input int unsigned s);
        logic [63:0] r;
        r = '0;
        if (s < n_of(c)) begin
            for (int unsigned b = 0; b < w_of(c); b++) r[b] = d[s * w_of(c) + b];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    bit          hold_pend;
    logic [63:0] hold_d;
    logic        hold_e;

    always @(negedge clk) begin
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", obs_ovalid, 1);
                chk("hold_data", obs_odata, hold_d);
                chk("hold_err", obs_oerr, hold_e);
            end
            hold_pend = obs_ovalid && !drv_oready;
            hold_d    = obs_odata;
            hold_e    = obs_oerr;
            if (obs_ovalid && drv_oready) begin
                if (sb.size() == 0) begin
                    chk("out_spurious", obs_ovalid, 0);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    out_cnt++;
                    chk("out_data", obs_odata, b.d);
                    chk("out_err", obs_oerr, b.e);
                    if (lat_chk) chk("latency", 64'(cyc + 1 - b.acc), 64'(s_of(cur)));
                end
            end
            if (drv_valid && obs_ready) begin
                beat_t b;
                b.d   = model_word(cur, drv_data, drv_sel);
                b.e   = (drv_sel >= n_of(cur));
                b.acc = cyc + 1;
                sb.push_back(b);
            end
        end
    end

    task automatic set_pattern(input int c);
        logic [63:0] p;
        drv_data = '0;
        for (int unsigned k = 0; k < n_of(c); k++) begin
            p = pat(c, k);
            for (int unsigned b = 0; b < w_of(c); b++) drv_data[k * w_of(c) + b] = p[b];
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < 64; k++) drv_data[k*32 +: 32] = $urandom;
    endtask

    task automatic send(input logic [5:0] s);
        bit done;
        done      = 1'b0;
        drv_sel   = s;
        drv_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = obs_ready;
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
        chk("send_accept", done, 1);
    endtask

    task automatic drain();
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        for (int i = 0; i < 200 && (sb.size() != 0 || obs_ovalid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sb.size()), 0);
    endtask

    task automatic rand_run(input int cycles, input int unsigned selmax);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (!drv_valid || acc) begin
                drv_valid = ($urandom_range(0, 3) != 0);
                drv_sel   = 6'($urandom_range(0, selmax));
                rand_data();
            end
            drv_oready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = drv_valid && obs_ready;
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned base, nin, nout;
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        out_cnt    = 0;
        lat_chk    = 1'b0;
        cur        = 0;
        drv_valid  = 1'b0;
        drv_oready = 1'b1;
        drv_sel    = '0;
        drv_data   = '0;
        reset_n    = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", obs_ovalid, 0);
        chk("rst_out_data", obs_odata, 0);
        chk("rst_out_err", obs_oerr, 0);
        chk("rst_in_ready", obs_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Full sweep of selects, back to back
        set_pattern(0);
        lat_chk = 1'b1;
        base    = out_cnt;
        for (int unsigned s = 0; s < 32; s++) send(6'(s));
        drain();
        chk("sweep_count", 64'(out_cnt - base), 32);

        // Backpressure fill and ordered drain
        lat_chk    = 1'b0;
        drv_oready = 1'b0;
        send(6'd5);
        send(6'd9);
        chk("bp_ready_2", obs_ready, 1);
        send(6'd17);
        chk("bp_ready_3", obs_ready, 0);
        repeat (4) begin
            @(negedge clk);
            chk("bp_valid", obs_ovalid, 1);
            chk("bp_word5", obs_odata, 64'hA5A5_0000_0000_0005);
        end
        drain();

        // Full pipeline with simultaneous accept and emit
        drv_oready = 1'b0;
        send(6'd1);
        send(6'd2);
        send(6'd3);
        drv_oready = 1'b1;
        drv_valid  = 1'b1;
        nin  = 0;
        nout = 0;
        for (int i = 0; i < 10; i++) begin
            drv_sel = 6'($urandom_range(0, 31));
            @(negedge clk);
            chk("sim_ready", obs_ready, 1);
            if (drv_valid && obs_ready) nin++;
            if (obs_ovalid && drv_oready) nout++;
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b0;
        chk("sim_in_count", 64'(nin), 10);
        chk("sim_out_count", 64'(nout), 10);
        drain();

        // Asynchronous reset with beats in flight
        send(6'd10);
        send(6'd11);
        send(6'd12);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", obs_ovalid, 0);
        chk("mid_rst_data", obs_odata, 0);
        chk("mid_rst_err", obs_oerr, 0);
        chk("mid_rst_ready", obs_ready, 1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(6'd7);
        drain();

        lat_chk = 1'b0;
        rand_run(300, 31);
        drain();

        // Non-power-of-two configuration with out-of-range selects
        cur = 1;
        set_pattern(1);
        lat_chk = 1'b1;
        send(6'd19);
        send(6'd25);
        drain();
        lat_chk = 1'b0;
        rand_run(300, 31);
        drain();

        // Degenerate single-stage configuration
        cur = 2;
        set_pattern(2);
        lat_chk = 1'b1;
        send(6'd3);
        drain();
        lat_chk = 1'b0;
        rand_run(200, 3);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
